writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//   Feeds the 8-entry register file write port. Merges single-cycle ALU results with
//   buffered long-latency load results onto one registered write port, ALU first.
//   Keeps a per-register pending-load scoreboard. Issue logic uses the combinational
//   hazard output to stall reads of registers whose load has not yet written back.
// PARAMETERS
//   DATA_W      32  register/result width
//   ADDR_W      3   register index width (2**ADDR_W registers, x0 hardwired zero)
//   FIFO_DEPTH  2   load-result buffer entries (>=1)
// PORTS
//   clk           in   1            clock, all state on rising edge
//   rst_n         in   1            synchronous active-low reset
//   issue_valid   in   1            instruction issued this cycle
//   issue_is_load in   1            issued instruction is a load
//   issue_rd      in   ADDR_W       destination of issued instruction
//   alu_valid     in   1            ALU result present (no back-pressure, always taken)
//   alu_rd        in   ADDR_W       ALU destination
//   alu_value     in   DATA_W       ALU result
//   ld_valid      in   1            load response present
//   ld_ready      out  1            load response accepted when valid&ready
//   ld_rd         in   ADDR_W       load destination
//   ld_value      in   DATA_W       load data
//   rf_we         out  1            register file write enable (registered)
//   rf_rd         out  ADDR_W       register file write index (registered)
//   rf_wdata      out  DATA_W       register file write data (registered)
//   chk_rs1       in   ADDR_W       source 1 to check
//   chk_rs2       in   ADDR_W       source 2 to check
//   hazard        out  1            a checked source is pending
//   pending       out  2**ADDR_W    scoreboard bitmap, bit 0 always 0
//   wb_err        out  1            sticky protocol-error flag
// BEHAVIOUR
//   Reset (rst_n low at edge): rf_we=0, rf_rd=0, rf_wdata=0, FIFO empty, pending=0,
//     wb_err=0. ld_ready=0 while rst_n is low. Reset mid-operation discards buffered loads.
//   ld_ready = rst_n && (count < FIFO_DEPTH). A full FIFO never pushes, even on a pop
//     cycle. Push on ld_valid&&ld_ready.
//   Write select, every edge: alu_valid -> write ALU. Else FIFO non-empty -> pop head
//     (FIFO order) and write it. Else rf_we=0.
//   rd==0 writes: entry is consumed (ALU or popped load) but rf_we=0.
//   Latency: ALU accepted at edge N -> rf_we high in cycle after N.
//     Load accepted at edge N -> earliest pop at N+1 -> rf_we high after N+1.
//     No FIFO bypass.
//   Starvation: continuous alu_valid stalls the FIFO indefinitely; back-pressure
//     reaches the load path via ld_ready. This is by design.
//   Scoreboard:
//     - Set: issue_valid && issue_is_load && issue_rd!=0 sets pending[issue_rd].
//     - Clear: popping a load with rd!=0 clears pending[rd] at the same edge.
//     - Same-edge set and clear of one index: set wins.
//   hazard = (chk_rs1!=0 && pending[chk_rs1]) || (chk_rs2!=0 && pending[chk_rs2]).
//     Combinational from the registered pending bitmap.
//   wb_err set, sticky until reset, when either occurs:
//     - a load issues to an already-pending rd;
//     - alu_valid targets a pending rd!=0.
// TESTING
//   1 rst_n=0 for 3 cycles, ld_valid=1 -> ld_ready=0, rf_we=0, pending=0, wb_err=0.
//   2 alu_valid rd=3 val=0x1234 -> next cycle rf_we=1 rf_rd=3 rf_wdata=0x1234;
//     then rd=0 -> rf_we=0.
//   3 issue load rd=5 -> pending=0x20, hazard=1 with chk_rs1=5; ld_value=0xDEADBEEF,
//     rd=5 accepted at edge N -> rf write after N+1, pending=0, hazard=0.
//   4 FIFO holds load rd=4 while alu_valid rd=6 -> rf writes x6 first, x4 next cycle.
//   5 alu_valid held 4 cycles, 3 loads offered -> 2 accepted, ld_ready=0; after ALU
//     stops, both drain in order, then third accepted.
//   6 issue load rd=2 twice -> wb_err=1, stays 1 until reset. Reset with full FIFO
//     -> FIFO empty, pending=0, no rf_we afterwards.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results take priority over buffered load results,
// and a pending-load scoreboard drives the issue stage's read-hazard check.
module writeback_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic                 issue_is_load,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_value,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_rd,
  input  logic [DATA_W-1:0]    ld_value,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_rd,
  output logic [DATA_W-1:0]    rf_wdata,
  input  logic [ADDR_W-1:0]    chk_rs1,
  input  logic [ADDR_W-1:0]    chk_rs2,
  output logic                 hazard,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 wb_err
);

  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] value;
  } ld_entry_t;

  ld_entry_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic [NREG-1:0]  r_pending;
  logic             r_err;

  logic             w_push, w_pop, w_err_event;
  ld_entry_t        w_head;
  logic [NREG-1:0]  w_pending_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full buffer refuses new loads even on a pop cycle: no same-edge replace.
  assign ld_ready = rst_n && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push   = ld_valid && ld_ready;
  assign w_pop    = !alu_valid && (r_count != '0);
  assign w_head   = r_mem[r_head];

  assign w_err_event = (issue_valid && issue_is_load && issue_rd != '0 && r_pending[issue_rd]) ||
                       (alu_valid && alu_rd != '0 && r_pending[alu_rd]);

  always_comb begin
    // NOTE: full default first so every path assigns the vector and no latch is inferred.
    w_pending_next = r_pending;
    if (w_pop && w_head.rd != '0)
      w_pending_next[w_head.rd] = 1'b0;
    // Applied after the clear so a same-edge set on the same index wins.
    if (issue_valid && issue_is_load && issue_rd != '0)
      w_pending_next[issue_rd] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  // NOTE: payload storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_tail] <= '{rd: ld_rd, value: ld_value};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wdata  <= '0;
    end else begin
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      r_count   <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_pending <= w_pending_next;
      if (w_err_event) r_err <= 1'b1;

      // Writes to x0 still consume their source but never strobe the register file.
      if (alu_valid) begin
        rf_we    <= (alu_rd != '0);
        rf_rd    <= alu_rd;
        rf_wdata <= alu_value;
      end else if (w_pop) begin
        rf_we    <= (w_head.rd != '0);
        rf_rd    <= w_head.rd;
        rf_wdata <= w_head.value;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

  assign pending = r_pending;
  assign wb_err  = r_err;
  assign hazard  = (chk_rs1 != '0 && r_pending[chk_rs1]) ||
                   (chk_rs2 != '0 && r_pending[chk_rs2]);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a queue-based reference model predicts every
// write-port cycle, and a monitor compares each prediction against the DUT outputs.
module tb_writeback_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;
  localparam int NREG   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid, issue_is_load;
  logic [ADDR_W-1:0] issue_rd;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_value;
  logic              ld_valid, ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_value;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] chk_rs1, chk_rs2;
  logic              hazard;
  logic [NREG-1:0]   pending;
  logic              wb_err;

  writeback_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_value(ld_value),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
    .pending(pending), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; bit [ADDR_W-1:0] rd; bit [DATA_W-1:0] data; } wr_t;
  typedef struct { bit [ADDR_W-1:0] rd; bit [DATA_W-1:0] data; } ld_t;

  wr_t exp_q[$];
  ld_t m_fifo[$];
  ld_t offer_q[$];
  bit  m_pend [NREG];
  bit  m_err;
  int  n_pass  = 0;
  int  n_total = 0;
  bit  done    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [NREG-1:0] model_bitmap();
    logic [NREG-1:0] b;
    for (int i = 0; i < NREG; i++) b[i] = m_pend[i];
    return b;
  endfunction

  // Reference model: one predicted write-port result per rising edge.
  always @(posedge clk) begin : model
    wr_t w;
    ld_t e;
    bit  push;
    w = '{we: 1'b0, rd: '0, data: '0};
    if (!rst_n) begin
      m_fifo.delete();
      for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      m_err = 1'b0;
    end else begin
      push = ld_valid && (m_fifo.size() < DEPTH);
      if (issue_valid && issue_is_load && issue_rd != 0 && m_pend[issue_rd]) m_err = 1'b1;
      if (alu_valid && alu_rd != 0 && m_pend[alu_rd]) m_err = 1'b1;
      if (alu_valid) begin
        w = '{we: (alu_rd != 0), rd: alu_rd, data: alu_value};
      end else if (m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        w = '{we: (e.rd != 0), rd: e.rd, data: e.data};
        if (e.rd != 0) m_pend[e.rd] = 1'b0;
      end
      if (issue_valid && issue_is_load && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (push) m_fifo.push_back('{rd: ld_rd, data: ld_value});
    end
    exp_q.push_back(w);
  end

  initial begin : monitor
    wr_t w;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("scoreboard_nonempty", 0, 1);
      end else begin
        w = exp_q.pop_front();
        check("rf_we", rf_we, w.we);
        if (w.we) begin
          check("rf_rd", rf_rd, w.rd);
          check("rf_wdata", rf_wdata, w.data);
        end
      end
      check("pending", pending, model_bitmap());
      check("wb_err", wb_err, m_err);
      #2;
      check("ld_ready", ld_ready, rst_n && (m_fifo.size() < DEPTH));
      check("hazard", hazard, (chk_rs1 != 0 && m_pend[chk_rs1]) || (chk_rs2 != 0 && m_pend[chk_rs2]));
    end
  end

  // Presents the head of offer_q as a load response and retires it once accepted.
  task automatic step();
    bit acc;
    ld_valid = (offer_q.size() > 0);
    if (ld_valid) begin
      ld_rd    = offer_q[0].rd;
      ld_value = offer_q[0].data;
    end
    #1;
    acc = ld_valid && ld_ready;
    @(negedge clk);
    if (acc) void'(offer_q.pop_front());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : stimulus
    rst_n = 1'b0; issue_valid = 0; issue_is_load = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_value = 0; ld_valid = 0; ld_rd = 0; ld_value = 0;
    chk_rs1 = 0; chk_rs2 = 0;

    // Reset with a load offered: it must never be accepted.
    offer_q.push_back('{rd: 3'd1, data: 32'h1111_1111});
    steps(3);
    check("reset_ld_ready", ld_ready, 0);
    check("reset_pending", pending, 0);
    offer_q.delete();
    rst_n = 1'b1;
    step();

    // ALU write, then an ALU write to x0.
    alu_valid = 1; alu_rd = 3; alu_value = 32'h1234;
    step();
    check("t2_rf_rd", rf_rd, 3);
    alu_rd = 0; alu_value = 32'h5555;
    step();
    check("t2_x0_we", rf_we, 0);
    alu_valid = 0;
    step();

    // Load scoreboard and two-edge load latency.
    issue_valid = 1; issue_is_load = 1; issue_rd = 5; chk_rs1 = 5;
    step();
    check("t3_pending_set", pending, 8'h20);
    check("t3_hazard_set", hazard, 1);
    issue_valid = 0;
    offer_q.push_back('{rd: 3'd5, data: 32'hDEAD_BEEF});
    step();
    check("t3_no_bypass", rf_we, 0);
    step();
    check("t3_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("t3_hazard_clear", hazard, 0);
    chk_rs1 = 0;
    step();

    // ALU beats a buffered load arriving the same cycle.
    alu_valid = 1; alu_rd = 6; alu_value = 32'h6666;
    offer_q.push_back('{rd: 3'd4, data: 32'h4444});
    step();
    check("t4_alu_first", rf_rd, 6);
    alu_valid = 0;
    step();
    check("t4_load_next", rf_rd, 4);
    steps(2);

    // Starvation and back-pressure, then in-order drain.
    alu_valid = 1; alu_rd = 7;
    for (int i = 1; i <= 3; i++) offer_q.push_back('{rd: i[2:0], data: 32'hA000 + i});
    for (int i = 0; i < 4; i++) begin
      alu_value = 32'h7000 + i;
      step();
    end
    check("t5_backpressure", ld_ready, 0);
    alu_valid = 0;
    steps(6);

    // Double load issue sets the sticky error; reset with a full buffer clears all.
    issue_valid = 1; issue_is_load = 1; issue_rd = 2;
    steps(2);
    check("t6_err_set", wb_err, 1);
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7;
    offer_q.push_back('{rd: 3'd2, data: 32'hB001});
    offer_q.push_back('{rd: 3'd2, data: 32'hB002});
    steps(3);
    check("t6_err_sticky", wb_err, 1);
    check("t6_full", ld_ready, 0);
    rst_n = 0; alu_valid = 0; offer_q.delete();
    step();
    rst_n = 1;
    steps(4);
    check("t6_err_cleared", wb_err, 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if (!rst_n) offer_q.delete();
      issue_valid   = ($urandom_range(0, 9) < 3);
      issue_is_load = ($urandom_range(0, 9) < 7);
      issue_rd      = 3'($urandom_range(0, 7));
      alu_valid     = ($urandom_range(0, 9) < 4);
      alu_rd        = 3'($urandom_range(0, 7));
      alu_value     = $urandom;
      chk_rs1       = 3'($urandom_range(0, 7));
      chk_rs2       = 3'($urandom_range(0, 7));
      if (offer_q.size() < 3 && $urandom_range(0, 2) == 0)
        offer_q.push_back('{rd: 3'($urandom_range(0, 7)), data: $urandom});
      step();
    end

    alu_valid = 0; issue_valid = 0; offer_q.delete();
    steps(4);
    done = 1;
    @(negedge clk);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
